// File: rtl/bbox_raster_sequencer_if.sv
// Handshake bundle between triangle setup, the bbox raster sequencer and the pixel stage.
// master = upstream/downstream environment side, slave = sequencer side.
interface bbox_raster_sequencer_if #(
   parameter int PIX_W = 10
);
   logic             tri_valid;
   logic             tri_ready;
   logic [15:0]      v0x;
   logic [15:0]      v1x;
   logic [15:0]      v2x;
   logic [15:0]      v0y;
   logic [15:0]      v1y;
   logic [15:0]      v2y;
   logic             pix_valid;
   logic             pix_ready;
   logic [PIX_W-1:0] pix_x;
   logic [PIX_W-1:0] pix_y;
   logic             pix_last;
   logic             tri_done;

   modport master (
      output tri_valid, v0x, v1x, v2x, v0y, v1y, v2y, pix_ready,
      input  tri_ready, pix_valid, pix_x, pix_y, pix_last, tri_done
   );

   modport slave (
      input  tri_valid, v0x, v1x, v2x, v0y, v1y, v2y, pix_ready,
      output tri_ready, pix_valid, pix_x, pix_y, pix_last, tri_done
   );
endinterface

// File: rtl/bbox_raster_sequencer.sv
// Bounding-box raster sequencer: latches one triangle, rounds/clamps its box, walks it in raster order.
// Define BBOX_PERF_EN to add pix_count_o / tri_count_o performance counters.
//
// state  | meaning
// IDLE   | tri_ready high, waiting for a triangle
// CALC   | one cycle computing rounded, clamped bbox from captured vertices
// SCAN   | presenting pixels, advancing on each handshake
// DONE   | tri_done pulse; tri_ready returns the cycle after
module bbox_raster_sequencer #(
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480,
   parameter int PIX_W    = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   bbox_raster_sequencer_if.slave bus
`ifdef BBOX_PERF_EN
   ,
   output logic [31:0]            pix_count_o,
   output logic [15:0]            tri_count_o
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_SCAN, S_DONE} state_t;

   localparam logic [10:0] X_LIM = 11'(SCREEN_W - 1);
   localparam logic [10:0] Y_LIM = 11'(SCREEN_H - 1);

   state_t state_q, state_d;

   // Only bits [15:5] matter: the integer part plus the half bit used for rounding.
   logic [10:0]      vx_q [3];
   logic [10:0]      vx_d [3];
   logic [10:0]      vy_q [3];
   logic [10:0]      vy_d [3];
   logic [PIX_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
   logic [PIX_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;

   logic [10:0] xmin_r, xmax_r, ymin_r, ymax_r, xmax_c, ymax_c;
   logic        box_empty;
   logic        pix_hs;
   logic        at_x_end;
   logic        at_last;

   function automatic logic [10:0] round_sat(input logic [10:0] t);
      logic [10:0] s;
      s = {1'b0, t[10:1]} + {10'd0, t[0]};
      return (s > 11'd1023) ? 11'd1023 : s;
   endfunction

   function automatic logic [10:0] min3(input logic [10:0] a, input logic [10:0] b,
                                        input logic [10:0] c);
      logic [10:0] m;
      m = (a < b) ? a : b;
      return (c < m) ? c : m;
   endfunction

   function automatic logic [10:0] max3(input logic [10:0] a, input logic [10:0] b,
                                        input logic [10:0] c);
      logic [10:0] m;
      m = (a > b) ? a : b;
      return (c > m) ? c : m;
   endfunction

   // Rounding is monotonic, so min/max of raw values then rounding equals rounding first.
   always_comb begin
      xmin_r    = round_sat(min3(vx_q[0], vx_q[1], vx_q[2]));
      xmax_r    = round_sat(max3(vx_q[0], vx_q[1], vx_q[2]));
      ymin_r    = round_sat(min3(vy_q[0], vy_q[1], vy_q[2]));
      ymax_r    = round_sat(max3(vy_q[0], vy_q[1], vy_q[2]));
      xmax_c    = (xmax_r > X_LIM) ? X_LIM : xmax_r;
      ymax_c    = (ymax_r > Y_LIM) ? Y_LIM : ymax_r;
      box_empty = (xmin_r > X_LIM) || (ymin_r > Y_LIM);
   end

   assign pix_hs   = (state_q == S_SCAN) && bus.pix_ready;
   assign at_x_end = (cur_x_q == xmax_q);
   assign at_last  = at_x_end && (cur_y_q == ymax_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (bus.tri_valid) state_d = S_CALC;
         S_CALC: state_d = box_empty ? S_DONE : S_SCAN;
         S_SCAN: if (pix_hs && at_last) state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.tri_ready = (state_q == S_IDLE);
      bus.pix_valid = (state_q == S_SCAN);
      bus.pix_last  = (state_q == S_SCAN) && at_last;
      bus.tri_done  = (state_q == S_DONE);
      bus.pix_x     = cur_x_q;
      bus.pix_y     = cur_y_q;
   end

   always_comb begin
      vx_d    = vx_q;
      vy_d    = vy_q;
      xmin_d  = xmin_q;
      xmax_d  = xmax_q;
      ymin_d  = ymin_q;
      ymax_d  = ymax_q;
      cur_x_d = cur_x_q;
      cur_y_d = cur_y_q;
      if (state_q == S_IDLE && bus.tri_valid) begin
         vx_d[0] = bus.v0x[15:5];
         vx_d[1] = bus.v1x[15:5];
         vx_d[2] = bus.v2x[15:5];
         vy_d[0] = bus.v0y[15:5];
         vy_d[1] = bus.v1y[15:5];
         vy_d[2] = bus.v2y[15:5];
      end
      if (state_q == S_CALC && !box_empty) begin
         xmin_d  = PIX_W'(xmin_r);
         xmax_d  = PIX_W'(xmax_c);
         ymin_d  = PIX_W'(ymin_r);
         ymax_d  = PIX_W'(ymax_c);
         cur_x_d = PIX_W'(xmin_r);
         cur_y_d = PIX_W'(ymin_r);
      end
      // The last pixel leaves the cursor parked on (xmax, ymax) so it never wraps.
      if (pix_hs && !at_last) begin
         if (!at_x_end) begin
            cur_x_d = cur_x_q + 1'b1;
         end else begin
            cur_x_d = xmin_q;
            cur_y_d = cur_y_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            vx_q[i] <= '0;
            vy_q[i] <= '0;
         end
         xmin_q  <= '0;
         xmax_q  <= '0;
         ymin_q  <= '0;
         ymax_q  <= '0;
         cur_x_q <= '0;
         cur_y_q <= '0;
      end else begin
         vx_q    <= vx_d;
         vy_q    <= vy_d;
         xmin_q  <= xmin_d;
         xmax_q  <= xmax_d;
         ymin_q  <= ymin_d;
         ymax_q  <= ymax_d;
         cur_x_q <= cur_x_d;
         cur_y_q <= cur_y_d;
      end
   end

`ifdef BBOX_PERF_EN
   logic [31:0] pix_count_q, pix_count_d;
   logic [15:0] tri_count_q, tri_count_d;

   always_comb begin
      pix_count_d = pix_count_q + {31'd0, pix_hs};
      tri_count_d = tri_count_q + {15'd0, (state_q == S_DONE)};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_count_q <= '0;
         tri_count_q <= '0;
      end else begin
         pix_count_q <= pix_count_d;
         tri_count_q <= tri_count_d;
      end
   end

   assign pix_count_o = pix_count_q;
   assign tri_count_o = tri_count_q;
`endif

endmodule

// File: tb/tb_bbox_raster_sequencer.sv
// Directed self-checking bench for bbox_raster_sequencer: raster order, rounding, clipping,
// clamping, backpressure and asynchronous reset mid-scan.
module tb_bbox_raster_sequencer;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   bbox_raster_sequencer_if #(.PIX_W(10)) bus ();

`ifdef BBOX_PERF_EN
   logic [31:0] pix_count;
   logic [15:0] tri_count;
`endif

   bbox_raster_sequencer #(
      .SCREEN_W (640),
      .SCREEN_H (480),
      .PIX_W    (10)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
`ifdef BBOX_PERF_EN
      ,
      .pix_count_o (pix_count),
      .tri_count_o (tri_count)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns in the cycle two after acceptance (first pixel / tri_done cycle).
   task automatic send_tri(input string tag, input logic [15:0] x0, input logic [15:0] x1,
                           input logic [15:0] x2, input logic [15:0] y0,
                           input logic [15:0] y1, input logic [15:0] y2);
      int waited;
      waited = 0;
      bus.v0x = x0; bus.v1x = x1; bus.v2x = x2;
      bus.v0y = y0; bus.v1y = y1; bus.v2y = y2;
      bus.tri_valid = 1'b1;
      while (!bus.tri_ready && waited < 50) begin
         tick();
         waited++;
      end
      check({tag, "_accept_timeout"}, 32'(waited >= 50), 32'd0);
      tick();
      bus.tri_valid = 1'b0;
      check({tag, "_calc_pix_valid"}, 32'(bus.pix_valid), 32'd0);
      check({tag, "_calc_tri_ready"}, 32'(bus.tri_ready), 32'd0);
      tick();
   endtask

   task automatic run_scan(input string tag, input int exmin, input int exmax,
                           input int eymin, input int eymax, input bit toggle);
      int         ex, ey, n, exp_n;
      bit         stalled, seen_done;
      logic [9:0] hx, hy;
      logic       hl;
      ex = exmin; ey = eymin; n = 0;
      exp_n = (exmax - exmin + 1) * (eymax - eymin + 1);
      stalled = 1'b0; seen_done = 1'b0;
      hx = '0; hy = '0; hl = 1'b0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         if (bus.tri_done) begin
            seen_done = 1'b1;
            break;
         end
         if (bus.pix_valid) begin
            if (stalled) begin
               check({tag, "_stall_x"}, 32'(bus.pix_x), 32'(hx));
               check({tag, "_stall_y"}, 32'(bus.pix_y), 32'(hy));
               check({tag, "_stall_last"}, 32'(bus.pix_last), 32'(hl));
            end
            if (bus.pix_ready) begin
               check({tag, "_pix_x"}, 32'(bus.pix_x), 32'(ex));
               check({tag, "_pix_y"}, 32'(bus.pix_y), 32'(ey));
               check({tag, "_pix_last"}, 32'(bus.pix_last), 32'(n == exp_n - 1));
               n++;
               if (ex < exmax) ex++;
               else begin
                  ex = exmin;
                  ey++;
               end
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               hx = bus.pix_x; hy = bus.pix_y; hl = bus.pix_last;
            end
         end
         tick();
         if (toggle) bus.pix_ready = ~bus.pix_ready;
      end
      check({tag, "_done_seen"}, 32'(seen_done), 32'd1);
      check({tag, "_pix_count"}, 32'(n), 32'(exp_n));
      check({tag, "_done_pix_valid"}, 32'(bus.pix_valid), 32'd0);
      check({tag, "_done_tri_ready"}, 32'(bus.tri_ready), 32'd0);
      tick();
      check({tag, "_post_tri_ready"}, 32'(bus.tri_ready), 32'd1);
      check({tag, "_post_tri_done"}, 32'(bus.tri_done), 32'd0);
      bus.pix_ready = 1'b1;
   endtask

   initial begin
      rst = 1'b1;
      bus.tri_valid = 1'b0;
      bus.pix_ready = 1'b1;
      bus.v0x = '0; bus.v1x = '0; bus.v2x = '0;
      bus.v0y = '0; bus.v1y = '0; bus.v2y = '0;
      #2;
      check("rst_tri_ready", 32'(bus.tri_ready), 32'd1);
      check("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
      check("rst_pix_last", 32'(bus.pix_last), 32'd0);
      check("rst_tri_done", 32'(bus.tri_done), 32'd0);
      check("rst_pix_x", 32'(bus.pix_x), 32'd0);
      check("rst_pix_y", 32'(bus.pix_y), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // 2x3 box: x 1..3, y 2..3
      send_tri("t1", 16'h0040, 16'h00C0, 16'h0080, 16'h0080, 16'h0080, 16'h00C0);
      check("t1_latency", 32'(bus.pix_valid), 32'd1);
      run_scan("t1", 1, 3, 2, 3, 1'b0);

      send_tri("t2a", 16'h0060, 16'h0060, 16'h0060, 16'h0000, 16'h0000, 16'h0000);
      check("t2a_latency", 32'(bus.pix_valid), 32'd1);
      run_scan("t2a", 2, 2, 0, 0, 1'b0);

      send_tri("t2b", 16'h005F, 16'h005F, 16'h005F, 16'h0000, 16'h0000, 16'h0000);
      check("t2b_latency", 32'(bus.pix_valid), 32'd1);
      run_scan("t2b", 1, 1, 0, 0, 1'b0);

      // Entirely right of the screen: no pixels, tri_done at N+2, ready at N+3
      send_tri("t3", 16'hAF00, 16'hAF00, 16'hAF00, 16'h0000, 16'h0000, 16'h0000);
      check("t3_tri_done", 32'(bus.tri_done), 32'd1);
      check("t3_pix_valid", 32'(bus.pix_valid), 32'd0);
      check("t3_tri_ready_early", 32'(bus.tri_ready), 32'd0);
      tick();
      check("t3_tri_ready", 32'(bus.tri_ready), 32'd1);
      check("t3_done_once", 32'(bus.tri_done), 32'd0);
      check("t3_no_pix", 32'(bus.pix_valid), 32'd0);

      // 630.0..700.0 clamps to 630..639, y = 1
      send_tri("t4", 16'h9D80, 16'hAF00, 16'h9D80, 16'h0040, 16'h0040, 16'h0040);
      check("t4_latency", 32'(bus.pix_valid), 32'd1);
      run_scan("t4", 630, 639, 1, 1, 1'b0);

      send_tri("t5", 16'h0040, 16'h00C0, 16'h0080, 16'h0080, 16'h0080, 16'h00C0);
      check("t5_latency", 32'(bus.pix_valid), 32'd1);
      run_scan("t5", 1, 3, 2, 3, 1'b1);

      // Reset while the 3rd pixel is presented
      send_tri("t6", 16'h0040, 16'h00C0, 16'h0080, 16'h0080, 16'h0080, 16'h00C0);
      check("t6_latency", 32'(bus.pix_valid), 32'd1);
      tick();
      tick();
      check("t6_third_x", 32'(bus.pix_x), 32'd3);
      check("t6_third_y", 32'(bus.pix_y), 32'd2);
      rst = 1'b1;
      #1;
      check("t6_rst_pix_valid", 32'(bus.pix_valid), 32'd0);
      check("t6_rst_tri_ready", 32'(bus.tri_ready), 32'd1);
      check("t6_rst_pix_x", 32'(bus.pix_x), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      send_tri("t6b", 16'h0140, 16'h0180, 16'h0140, 16'h0100, 16'h0100, 16'h0100);
      check("t6b_latency", 32'(bus.pix_valid), 32'd1);
      run_scan("t6b", 5, 6, 4, 4, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
